imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Writer side of the instruction memory. The core fetches `insn` from imem by `pc`; this block fills imem from a byte stream before the core runs.
- It holds the core in reset, receives a framed program over a valid/ready byte interface, and assembles little-endian 32-bit words.
- It writes each word to imem, checks an XOR checksum, then releases the core on success.

Parameters:
- ADDR_W, 10, imem word-address width (matches `pc` width); depth = 2**ADDR_W words.
- TIMEOUT_CYCLES, 1000, inter-byte timeout limit; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin a load.
- load_abort  input  1  abort the current load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  imem write strobe, one cycle per word.
- imem_addr  output  ADDR_W  imem word index.
- imem_wdata  output  32  imem write data.
- core_reset  output  1  active-high reset to the processor.
- busy  output  1  load in progress.
- done  output  1  last load succeeded (sticky).
- error  output  1  last load failed (sticky).

Behaviour:
- Reset (reset=0, asynchronous, immediate, including mid-load):
  - state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, busy=0, done=0, error=0.
  - All counters and the checksum are cleared.
- Byte transfer: a byte is accepted only on a rising edge with in_valid & in_ready. in_data is ignored otherwise.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (little-endian words, word 0 first), then one CSUM byte = XOR of all 4*N data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR.
  - IDLE/DONE/ERROR + load_start → LEN_LO on the next cycle. That cycle: core_reset=1, busy=1, done=0, error=0, word index=0, checksum=0.
  - load_start is ignored while busy.
  - LEN_LO, LEN_HI, DATA, CSUM: in_ready=1.
  - WRITE, IDLE, DONE, ERROR: in_ready=0.
  - LEN_HI accept → if N==0 or N>2**ADDR_W go to ERROR; else go to DATA.
  - DATA: byte k (0..3) of the current word goes to imem_wdata[8k+7:8k] and is XORed into the checksum. The 4th accept → WRITE.
  - WRITE, one cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word. Then the word index increments. Go to CSUM if the index now equals N, else DATA.
  - Throughput is 5 cycles per word with in_valid held high.
  - CSUM accept → DONE if the byte equals the checksum, else ERROR.
  - DONE: core_reset=0 and done=1 from the cycle after the CSUM accept; busy=0.
  - ERROR: core_reset=1, error=1, busy=0. Words already written remain in imem and are not rolled back.
- imem_addr holds its last value when imem_we=0. imem_we is never asserted outside WRITE.
- load_abort while busy → ERROR next cycle, with priority over a simultaneous byte accept. load_abort is ignored when not busy.
- The word index wraps only when N==2**ADDR_W. In that case the index reaches 2**ADDR_W and compares equal to N, which requires an ADDR_W+1-bit counter.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN_LO, LEN_HI, DATA and CSUM. It resets on every accepted byte and on state entry, and is held in WRITE.
  - When it reaches TIMEOUT_CYCLES without an accept, the state goes to ERROR next cycle.
- Undefined: no counter; the loader waits indefinitely for bytes.

Test Plan:
- Reset values: hold reset=0 and check outputs → core_reset=1, in_ready=0, imem_we=0, busy=done=error=0.
- Good load: load_start, then bytes 02 00 93 00 50 00 13 01 A0 00 71 → imem writes addr0=0x00500093, addr1=0x00A00113; each write is exactly 1 cycle; done=1, core_reset=0 the cycle after the 0x71 accept.
- Bad checksum: same stream with final byte 0x70 → both writes occur, then error=1, core_reset=1, done=0.
- Bad length: N=0 (00 00), and separately N=1025 (01 04) → ERROR right after LEN_HI, no imem_we.
- Stalls, abort and reset mid-load:
  - Random in_valid gaps → identical writes to the good load.
  - load_abort after the 2nd data byte → ERROR, no write.
  - reset=0 during DATA → immediate reset values.
  - A new load_start from ERROR → good load completes.
- Timeout (with LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=20): stop in_valid after LEN_HI → error=1 at 20 idle cycles; without the macro, still busy after 100 cycles.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: writer side of the instruction memory.
//   Holds the core in reset, receives a framed program over a valid/ready byte
//   stream (LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR checksum byte),
//   writes each assembled 32-bit word to imem, then releases the core on success.
//
// Optional feature: define LOADER_TIMEOUT_EN to abort a load with an error after
//   TIMEOUT_CYCLES cycles without an accepted byte.
//
// Ports:
//   i_clk          system clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_load_start   single-cycle request to begin a load (ignored while busy)
//   i_load_abort   abort the current load (ignored when not busy)
//   i_in_valid     byte-stream valid
//   i_in_data      byte-stream data
//   o_in_ready     loader can accept a byte
//   o_imem_we      imem write strobe, one cycle per word
//   o_imem_addr    imem word index
//   o_imem_wdata   imem write data
//   o_core_reset   active-high reset to the processor
//   o_busy         load in progress
//   o_done         last load succeeded (sticky)
//   o_error        last load failed (sticky)
module imem_boot_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic              i_load_abort,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] IdxOne = 1;

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StError
  } state_t;

  state_t            r_state, w_state_next;
  logic [15:0]       r_len;
  // One bit wider than the address so a full-depth load can reach Depth.
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   w_idx_inc;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_csum;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_imem_addr;

  logic        w_accept, w_take, w_start, w_timeout, w_len_bad, w_last_word;
  logic [15:0] w_len;

  assign o_in_ready = (r_state == StLenLo) || (r_state == StLenHi) ||
                      (r_state == StData)  || (r_state == StCsum);
  assign o_busy       = o_in_ready || (r_state == StWrite);
  assign o_imem_we    = (r_state == StWrite);
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_word;
  assign o_core_reset = (r_state != StDone);
  assign o_done       = (r_state == StDone);
  assign o_error      = (r_state == StError);

  assign w_accept = i_in_valid && o_in_ready;
  // Abort and timeout win over a byte offered in the same cycle.
  assign w_take   = w_accept && !i_load_abort && !w_timeout;
  assign w_start  = i_load_start && !o_busy;

  assign w_len       = {i_in_data, r_len[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > Depth);
  assign w_idx_inc   = r_word_idx + IdxOne;
  assign w_last_word = (32'(w_idx_inc) == 32'(r_len));

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoOne = 1;
  logic [TmoW-1:0] r_tmo;

  // The counter only runs in byte-waiting states, which are exactly the in_ready states.
  assign w_timeout = o_in_ready && !w_accept && (32'(r_tmo) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo <= '0;
    end else if ((w_state_next != r_state) || w_accept) begin
      r_tmo <= '0;
    end else if (o_in_ready) begin
      r_tmo <= r_tmo + TmoOne;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone, StError: if (i_load_start) w_state_next = StLenLo;
      StLenLo: if (w_take) w_state_next = StLenHi;
      StLenHi: if (w_take) w_state_next = w_len_bad ? StError : StData;
      StData:  if (w_take && (r_byte_cnt == 2'd3)) w_state_next = StWrite;
      StWrite: w_state_next = w_last_word ? StCsum : StData;
      StCsum:  if (w_take) w_state_next = (i_in_data == r_csum) ? StDone : StError;
      default: w_state_next = StIdle;
    endcase
    if (o_busy && (i_load_abort || w_timeout)) w_state_next = StError;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_imem_addr <= '0;
    end else if (w_start) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
    end else begin
      if (w_take && (r_state == StLenLo)) r_len[7:0]  <= i_in_data;
      if (w_take && (r_state == StLenHi)) r_len[15:8] <= i_in_data;
      if (w_take && (r_state == StData)) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= i_in_data;
        r_csum     <= r_csum ^ i_in_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // Latch the address only when the word completes so it holds between writes.
        if (r_byte_cnt == 2'd3) r_imem_addr <= r_word_idx[ADDR_W-1:0];
      end
      if (r_state == StWrite) r_word_idx <= w_idx_inc;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;

  typedef logic [7:0] frame_t [11];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start, load_abort, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, imem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  int                wr_cyc  [$];

  frame_t good_frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                         8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
  frame_t bad_frame  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                         8'h13, 8'h01, 8'hA0, 8'h00, 8'h70};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  imem_boot_loader #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(20)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_start (load_start),
    .i_load_abort (load_abort),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_core_reset (core_reset),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) break;
      if (n >= 40) begin
        check_eq("byte_accept", {31'd0, rdy}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int max_gap);
    for (int i = 0; i < 11; i++) begin
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
      check_eq({tag, "_d0"}, wr_data[0], 32'h0050_0093);
      check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
      check_eq({tag, "_d1"}, wr_data[1], 32'h00A0_0113);
    end
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_busy, input logic e_creset);
    check_eq({tag, "_done"}, 32'(done), 32'(e_done));
    check_eq({tag, "_error"}, 32'(error), 32'(e_err));
    check_eq({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check_eq({tag, "_core_reset"}, 32'(core_reset), 32'(e_creset));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;

    // Reset values
    #13;
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Good load, back-to-back bytes
    start_load();
    check_status("start", 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("start_in_ready", 32'(in_ready), 32'd1);
    send_frame(good_frame, 0);
    check_writes("good");
    if (wr_cyc.size() == 2) check_eq("good_rate", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("good_addr_hold", 32'(imem_addr), 32'd1);
    check_eq("good_in_ready", 32'(in_ready), 32'd0);

    // Bad checksum, starting from DONE
    start_load();
    check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(bad_frame, 0);
    check_writes("badcs");
    check_status("badcs", 1'b0, 1'b1, 1'b0, 1'b1);

    // Good load with random stalls, starting from ERROR
    start_load();
    send_frame(good_frame, 3);
    check_writes("stall");
    check_status("stall", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad length N=0
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_status("len0", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("len0_nwr", wr_addr.size(), 0);

    // Bad length N=1025
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check_status("len1025", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("len1025_nwr", wr_addr.size(), 0);

    // Abort after the 2nd data byte, with a byte offered in the same cycle
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    load_abort = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h50;
    tick();
    load_abort = 1'b0;
    in_valid   = 1'b0;
    check_status("abort", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) tick();
    check_eq("abort_nwr", wr_addr.size(), 0);
    check_eq("abort_stays", 32'(error), 32'd1);

    // Asynchronous reset during DATA
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    #2 rst_n = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_addr", 32'(imem_addr), 32'd0);
    check_eq("midrst_wdata", imem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Good load after reset
    start_load();
    send_frame(good_frame, 0);
    check_writes("post_rst");
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall after LEN_HI
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_TIMEOUT_EN
    repeat (19) tick();
    check_eq("tmo_before", 32'(error), 32'd0);
    tick();
    check_status("tmo", 1'b0, 1'b1, 1'b0, 1'b1);
`else
    repeat (100) tick();
    check_status("no_tmo", 1'b0, 1'b0, 1'b1, 1'b1);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check_status("no_tmo_abort", 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
